// File: rtl/wb_sample_fifo.sv
// Wishbone B4 classic slave sample FIFO: DATA push/pop, STATUS, CTRL (flush, sticky clear, irq threshold).
// Every accepted access ends with exactly one single-cycle ack or err pulse.
module wb_sample_fifo #(
    parameter int dw    = 32,
    parameter int aw    = 32,
    parameter int DEPTH = 16
) (
    input  logic            wb_clk,
    input  logic            wb_rst_n,
    input  logic [aw-1:0]   wb_s_adr_i,
    input  logic [dw-1:0]   wb_s_dat_i,
    input  logic [3:0]      wb_s_sel_i,
    input  logic            wb_s_we_i,
    input  logic            wb_s_cyc_i,
    input  logic            wb_s_stb_i,
    input  logic [2:0]      wb_s_cti_i,
    input  logic [1:0]      wb_s_bte_i,
    output logic [dw-1:0]   wb_s_dat_o,
    output logic            wb_s_ack_o,
    output logic            wb_s_err_o,
    output logic            wb_s_rty_o,
    output logic            irq_o,
    output logic            full_o,
    output logic            empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    logic [dw-1:0] mem [DEPTH];

    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic [7:0]    thr_reg, thr_next;
    logic          ovf_reg, ovf_next;
    logic          unf_reg, unf_next;
    logic          ack_next, err_next;
    logic [dw-1:0] dat_next;
    logic          push;
    logic          accept;
    logic [8:0]    count9_reg, count9_next;
    logic [1:0]    rst_sync;
    logic          rst_n_int;

    // Assertion is immediate; release is retimed to wb_clk so no flop sees a racy deassert.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) rst_sync <= 2'b00;
        else           rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n_int = rst_sync[1];

    assign accept      = wb_s_cyc_i & wb_s_stb_i & ~wb_s_ack_o & ~wb_s_err_o;
    assign wb_s_rty_o  = 1'b0;
    assign count9_reg  = 9'(count_reg);
    assign count9_next = 9'(count_next);

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        thr_next    = thr_reg;
        ovf_next    = ovf_reg;
        unf_next    = unf_reg;
        ack_next    = 1'b0;
        err_next    = 1'b0;
        dat_next    = '0;
        push        = 1'b0;
        if (accept) begin
            case (wb_s_adr_i[3:2])
                REG_DATA: begin
                    if (wb_s_we_i) begin
                        if (wb_s_sel_i != 4'hF) begin
                            err_next = 1'b1;
                        end else if (full_o) begin
                            err_next = 1'b1;
                            ovf_next = 1'b1;
                        end else begin
                            ack_next    = 1'b1;
                            push        = 1'b1;
                            wr_ptr_next = wr_ptr_reg + PW'(1);
                            count_next  = count_reg + CW'(1);
                        end
                    end else begin
                        if (empty_o) begin
                            err_next = 1'b1;
                            unf_next = 1'b1;
                        end else begin
                            ack_next    = 1'b1;
                            dat_next    = mem[rd_ptr_reg];
                            rd_ptr_next = rd_ptr_reg + PW'(1);
                            count_next  = count_reg - CW'(1);
                        end
                    end
                end
                REG_STATUS: begin
                    if (wb_s_we_i) begin
                        err_next = 1'b1;
                    end else begin
                        ack_next = 1'b1;
                        dat_next = {14'b0, unf_reg, ovf_reg, count9_reg[7:0], 6'b0, full_o, empty_o};
                    end
                end
                REG_CTRL: begin
                    ack_next = 1'b1;
                    if (wb_s_we_i) begin
                        if (wb_s_sel_i[0] && wb_s_dat_i[0]) begin
                            rd_ptr_next = '0;
                            wr_ptr_next = '0;
                            count_next  = '0;
                        end
                        if (wb_s_sel_i[0] && wb_s_dat_i[1]) begin
                            ovf_next = 1'b0;
                            unf_next = 1'b0;
                        end
                        if (wb_s_sel_i[1]) thr_next = wb_s_dat_i[15:8];
                    end else begin
                        dat_next = {16'b0, thr_reg, 8'b0};
                    end
                end
                default: err_next = 1'b1;
            endcase
        end
    end

    always_ff @(posedge wb_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            thr_reg    <= '0;
            ovf_reg    <= 1'b0;
            unf_reg    <= 1'b0;
            wb_s_ack_o <= 1'b0;
            wb_s_err_o <= 1'b0;
            wb_s_dat_o <= '0;
            irq_o      <= 1'b0;
            full_o     <= 1'b0;
            empty_o    <= 1'b1;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            thr_reg    <= thr_next;
            ovf_reg    <= ovf_next;
            unf_reg    <= unf_next;
            wb_s_ack_o <= ack_next;
            wb_s_err_o <= err_next;
            wb_s_dat_o <= dat_next;
            irq_o      <= (thr_next != 8'd0) && (count9_next >= {1'b0, thr_next});
            full_o     <= (count_next == CW'(DEPTH));
            empty_o    <= (count_next == '0);
        end
    end

    // Storage is never reset or cleared; flush only moves the pointers.
    always_ff @(posedge wb_clk) begin
        if (push) mem[wr_ptr_reg] <= wb_s_dat_i;
    end

    logic unused_inputs;
    assign unused_inputs = ^{wb_s_adr_i[aw-1:4], wb_s_adr_i[1:0], wb_s_dat_i[dw-1:16],
                             wb_s_dat_i[7:2], wb_s_sel_i[3:2], wb_s_cti_i, wb_s_bte_i};
endmodule

// File: tb/tb_wb_sample_fifo.sv
// Directed self-checking bench for wb_sample_fifo (DEPTH=16): register map, FIFO order,
// overflow/underflow, threshold irq, flush, pointer wrap, error terminations, async reset.
module tb_wb_sample_fifo;
    localparam logic [31:0] A_DATA = 32'h0, A_STAT = 32'h4, A_CTRL = 32'h8, A_RSVD = 32'hC;

    logic        wb_clk = 1'b0;
    logic        wb_rst_n = 1'b0;
    logic [31:0] wb_s_adr_i = '0;
    logic [31:0] wb_s_dat_i = '0;
    logic [3:0]  wb_s_sel_i = '0;
    logic        wb_s_we_i = 1'b0;
    logic        wb_s_cyc_i = 1'b0;
    logic        wb_s_stb_i = 1'b0;
    logic [2:0]  wb_s_cti_i = '0;
    logic [1:0]  wb_s_bte_i = '0;
    logic [31:0] wb_s_dat_o;
    logic        wb_s_ack_o, wb_s_err_o, wb_s_rty_o;
    logic        irq_o, full_o, empty_o;

    int vectors = 0;
    int miscompares = 0;
    logic        irq_at_term;
    logic [31:0] rdat;
    logic        got_ack, got_err;

    wb_sample_fifo #(.dw(32), .aw(32), .DEPTH(16)) dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
        .wb_s_adr_i(wb_s_adr_i), .wb_s_dat_i(wb_s_dat_i), .wb_s_sel_i(wb_s_sel_i),
        .wb_s_we_i(wb_s_we_i), .wb_s_cyc_i(wb_s_cyc_i), .wb_s_stb_i(wb_s_stb_i),
        .wb_s_cti_i(wb_s_cti_i), .wb_s_bte_i(wb_s_bte_i),
        .wb_s_dat_o(wb_s_dat_o), .wb_s_ack_o(wb_s_ack_o), .wb_s_err_o(wb_s_err_o),
        .wb_s_rty_o(wb_s_rty_o), .irq_o(irq_o), .full_o(full_o), .empty_o(empty_o)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                        input logic [3:0] sel);
        logic done;
        @(posedge wb_clk); #1;
        wb_s_adr_i = adr; wb_s_we_i = we; wb_s_dat_i = wdat; wb_s_sel_i = sel;
        wb_s_cyc_i = 1'b1; wb_s_stb_i = 1'b1;
        done = 1'b0; got_ack = 1'b0; got_err = 1'b0; rdat = '0;
        for (int i = 0; i < 8 && !done; i++) begin
            @(posedge wb_clk); #1;
            if (wb_s_ack_o || wb_s_err_o) begin
                done = 1'b1;
                got_ack = wb_s_ack_o; got_err = wb_s_err_o;
                rdat = wb_s_dat_o; irq_at_term = irq_o;
            end
        end
        wb_s_cyc_i = 1'b0; wb_s_stb_i = 1'b0; wb_s_we_i = 1'b0;
        check("termination_timeout", {31'b0, done}, 32'd1);
        $display("t=%0t adr=%h we=%0b sel=%h wdat=%08h -> ack=%0b err=%0b rdat=%08h irq=%0b",
                 $time, adr, we, sel, wdat, got_ack, got_err, rdat, irq_at_term);
    endtask

    task automatic push(input logic [31:0] v, input logic exp_err);
        xfer(A_DATA, 1'b1, v, 4'hF);
        check("push_term", {30'b0, got_ack, got_err}, exp_err ? 32'd1 : 32'd2);
    endtask

    task automatic pop(input logic [31:0] exp, input logic exp_err);
        xfer(A_DATA, 1'b0, '0, 4'hF);
        check("pop_term", {30'b0, got_ack, got_err}, exp_err ? 32'd1 : 32'd2);
        check("pop_data", rdat, exp);
    endtask

    task automatic rd_reg(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        xfer(adr, 1'b0, '0, 4'hF);
        check({tag, "_ack"}, {31'b0, got_ack}, 32'd1);
        check(tag, rdat, exp);
    endtask

    task automatic wr_reg(input string tag, input logic [31:0] adr, input logic [31:0] v,
                          input logic [3:0] sel, input logic exp_err);
        xfer(adr, 1'b1, v, sel);
        check(tag, {30'b0, got_ack, got_err}, exp_err ? 32'd1 : 32'd2);
    endtask

    initial begin
        irq_at_term = 1'b0;
        #23;
        check("rst_ack", {31'b0, wb_s_ack_o}, 32'd0);
        check("rst_err", {31'b0, wb_s_err_o}, 32'd0);
        check("rst_rty", {31'b0, wb_s_rty_o}, 32'd0);
        check("rst_dat", wb_s_dat_o, 32'd0);
        check("rst_flags", {29'b0, irq_o, full_o, empty_o}, 32'b001);
        @(negedge wb_clk); wb_rst_n = 1'b1;
        repeat (3) @(posedge wb_clk);

        rd_reg("status_after_reset", A_STAT, 32'h0000_0001);
        check("irq_after_reset", {31'b0, irq_o}, 32'd0);

        for (int i = 1; i <= 3; i++) push(32'hA5A5_0000 + i, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            pop(32'hA5A5_0000 + i, 1'b0);
            rd_reg("status_count", A_STAT, ((3 - i) << 8) | (i == 3 ? 32'd1 : 32'd0));
        end
        check("empty_after_pops", {31'b0, empty_o}, 32'd1);

        for (int i = 1; i <= 16; i++) push(i, 1'b0);
        push(32'd17, 1'b1);
        check("full_o", {31'b0, full_o}, 32'd1);
        rd_reg("status_full_ovf", A_STAT, 32'h0001_1002);
        for (int i = 1; i <= 16; i++) pop(i, 1'b0);
        pop(32'd0, 1'b1);
        rd_reg("status_unf", A_STAT, 32'h0003_0001);

        wr_reg("ctrl_thr4", A_CTRL, 32'h0000_0400, 4'hF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            push(32'hB000_0000 + i, 1'b0);
            check("irq_below_thr", {31'b0, irq_at_term}, 32'd0);
        end
        push(32'hB000_0003, 1'b0);
        check("irq_at_thr", {31'b0, irq_at_term}, 32'd1);
        pop(32'hB000_0000, 1'b0);
        check("irq_after_pop", {31'b0, irq_at_term}, 32'd0);
        rd_reg("ctrl_read", A_CTRL, 32'h0000_0400);

        for (int i = 0; i < 5; i++) push(32'hC000_0000 + i, 1'b0);
        rd_reg("status_count8", A_STAT, 32'h0003_0800);
        wr_reg("ctrl_flush_clr", A_CTRL, 32'h0000_0003, 4'hF, 1'b0);
        rd_reg("status_flushed", A_STAT, 32'h0000_0001);
        check("empty_after_flush", {31'b0, empty_o}, 32'd1);
        check("irq_thr0", {31'b0, irq_o}, 32'd0);

        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 4; k++) push(32'hD000_0000 + r * 4 + k, 1'b0);
            for (int k = 0; k < 4; k++) pop(32'hD000_0000 + r * 4 + k, 1'b0);
        end

        push(32'hE000_0001, 1'b0);
        wr_reg("ctrl_sel_thr_only", A_CTRL, 32'h0000_0501, 4'h2, 1'b0);
        rd_reg("status_no_flush", A_STAT, 32'h0000_0100);
        rd_reg("ctrl_thr5", A_CTRL, 32'h0000_0500);
        wr_reg("data_sel3_err", A_DATA, 32'h1234_5678, 4'h3, 1'b1);
        rd_reg("status_sel3", A_STAT, 32'h0000_0100);
        wr_reg("rsvd_wr_err", A_RSVD, 32'h0, 4'hF, 1'b1);
        xfer(A_RSVD, 1'b0, '0, 4'hF);
        check("rsvd_rd_err", {30'b0, got_ack, got_err}, 32'd1);
        wr_reg("status_wr_err", A_STAT, 32'hFFFF_FFFF, 4'hF, 1'b1);
        pop(32'hE000_0001, 1'b0);

        @(posedge wb_clk); #1;
        wb_s_adr_i = A_DATA; wb_s_we_i = 1'b1; wb_s_dat_i = 32'hF00D_0001; wb_s_sel_i = 4'hF;
        wb_s_cyc_i = 1'b1; wb_s_stb_i = 1'b1;
        @(posedge wb_clk); #1;
        check("ack_pending", {31'b0, wb_s_ack_o}, 32'd1);
        wb_rst_n = 1'b0;
        #1;
        check("ack_drop_on_reset", {31'b0, wb_s_ack_o}, 32'd0);
        check("flags_on_reset", {29'b0, irq_o, full_o, empty_o}, 32'b001);
        wb_s_cyc_i = 1'b0; wb_s_stb_i = 1'b0; wb_s_we_i = 1'b0;
        @(negedge wb_clk); wb_rst_n = 1'b1;
        repeat (3) @(posedge wb_clk);
        rd_reg("status_after_midreset", A_STAT, 32'h0000_0001);
        rd_reg("ctrl_after_midreset", A_CTRL, 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
